puf_chal_gen: RTL

Challenge responder and entropy collector for the PUF RNG mode. It answers the PUF controller's `request` / `ready_challenge` handshake with a fresh, never-zero 128-bit challenge from an internal LFSR. It also gathers the controller's 2-bit RNG outputs into 32-bit words and buffers them in a small FIFO for the bus side. It sits between the PUF controller and the register/bus interface of the PUF IP.

---
 rtl/puf_chal_gen.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/puf_chal_gen.sv
// puf_chal_gen
// Challenge responder and entropy collector for the PUF RNG mode.
//   - Answers the PUF controller's request/ready_challenge handshake with a
//     128-bit challenge taken from a Galois LFSR
//     (x^128 + x^29 + x^27 + x^2 + 1). The challenge is never zero.
//   - Packs the controller's 2-bit RNG results into 32-bit words and queues
//     them in a small FIFO for the bus side.
//
// Optional feature macro: PUF_CHAL_RESEED_EN
//   When defined, the most recent word pushed to the FIFO (dropped words
//   included) is XORed into LFSR[31:0] on the first STEP cycle of the next
//   challenge.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   en                block enable (en=0 forces the FSM back to IDLE)
//   seed_load, seed   load a new LFSR seed (honoured in IDLE only)
//   request           controller challenge request (level)
//   ready_challenge   one-cycle pulse, challenge valid
//   challenge         registered 128-bit challenge
//   rsp_valid_2bit    strobe for rsp_2bit
//   rsp_2bit          2-bit RNG result
//   rnd_valid         FIFO not empty
//   rnd_ready         consumer pops the head word
//   rnd_data          registered FIFO head word
//   fifo_level        occupied FIFO entries
//   overflow          sticky word-dropped flag
//   ovf_clr           clears overflow (a same-cycle drop wins)
module puf_chal_gen #(
  parameter logic [127:0] SEED       = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
  parameter int           STEP_CNT   = 8,
  parameter int           FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            seed_load,
  input  logic [127:0]                    seed,
  input  logic                            request,
  output logic                            ready_challenge,
  output logic [127:0]                    challenge,
  input  logic                            rsp_valid_2bit,
  input  logic [1:0]                      rsp_2bit,
  output logic                            rnd_valid,
  input  logic                            rnd_ready,
  output logic [31:0]                     rnd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int           LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int           PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [127:0] TAPS  = 128'h2800_0005;

  typedef enum logic [1:0] {IDLE, STEP, PRESENT, WAIT_DROP} state_t;

  state_t         state, state_nxt;
  logic [7:0]     step_cnt;
  logic [127:0]   lfsr, lfsr_nxt;
  logic           do_step, do_present, do_load;

  function automatic logic [127:0] zero_guard(input logic [127:0] v);
    return (v == '0) ? SEED : v;
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] v);
    logic [127:0] s;
    s = {v[126:0], 1'b0};
    if (v[127]) s = s ^ TAPS;
    return s;
  endfunction

  // Entropy accumulator: the 16th pair completes a word and pushes it on the
  // same edge, so push_word is the shifted-in value rather than acc itself.
  logic [31:0] acc;
  logic [3:0]  pair_cnt;
  logic        push;
  logic [31:0] push_word;

  assign push_word = {acc[29:0], rsp_2bit};
  assign push      = rsp_valid_2bit && (pair_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      pair_cnt <= '0;
    end else if (rsp_valid_2bit) begin
      acc      <= push_word;
      pair_cnt <= pair_cnt + 4'd1;
    end
  end

  // Challenge FSM
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (request) state_nxt = STEP;
        STEP:      if (step_cnt == 8'(STEP_CNT - 1)) state_nxt = PRESENT;
        PRESENT:   state_nxt = WAIT_DROP;
        WAIT_DROP: if (!request) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign do_step    = en && (state == STEP);
  assign do_present = en && (state == PRESENT);
  assign do_load    = seed_load && (state == IDLE);

`ifdef PUF_CHAL_RESEED_EN
  logic [31:0] reseed_word;
  logic        reseed_pend;
  logic        reseed_use;

  assign reseed_use = do_step && (step_cnt == 8'd0) && reseed_pend;

  always_comb begin
    lfsr_nxt = lfsr_step(lfsr);
    if (reseed_use) lfsr_nxt = lfsr_nxt ^ {96'd0, reseed_word};
    lfsr_nxt = zero_guard(lfsr_nxt);
  end

  // Only the latest word is kept; a push in the consuming cycle re-arms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reseed_word <= '0;
      reseed_pend <= 1'b0;
    end else if (push) begin
      reseed_word <= push_word;
      reseed_pend <= 1'b1;
    end else if (reseed_use) begin
      reseed_pend <= 1'b0;
    end
  end
`else
  assign lfsr_nxt = zero_guard(lfsr_step(lfsr));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr            <= SEED;
      step_cnt        <= '0;
      ready_challenge <= 1'b0;
      challenge       <= '0;
    end else begin
      ready_challenge <= do_present;
      if (do_present) challenge <= lfsr;
      if (do_load)      lfsr <= zero_guard(seed);
      else if (do_step) lfsr <= lfsr_nxt;
      if (state == IDLE) step_cnt <= '0;
      else if (do_step)  step_cnt <= step_cnt + 8'd1;
    end
  end

  // Random-word FIFO with a registered head
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr, rptr_nxt;
  logic [LVL_W-1:0] count, remain, count_nxt;
  logic             pop_ok, push_ok, drop;

  always_comb begin
    pop_ok    = (count != '0) && rnd_ready;
    push_ok   = push && ((count != LVL_W'(FIFO_DEPTH)) || pop_ok);
    drop      = push && !push_ok;
    remain    = count - LVL_W'(pop_ok);
    count_nxt = remain + LVL_W'(push_ok);
    rptr_nxt  = rptr + PTR_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rnd_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      rptr     <= rptr_nxt;
      count    <= count_nxt;
      overflow <= drop | (overflow & ~ovf_clr);
      // The head is the incoming word only when nothing older remains.
      if (push_ok && (remain == '0)) rnd_data <= push_word;
      else if (count_nxt == '0)      rnd_data <= '0;
      else                           rnd_data <= mem[rptr_nxt];
    end
  end

  assign rnd_valid  = (count != '0);
  assign fifo_level = count;

endmodule
